cdc_hs_sender: RTL and testbench

Source-side half of a 4-phase req/ack multi-bit clock-domain-crossing handshake. Accepts a word on a valid/ready interface in the source clock domain and holds it stable on `x_data`. It then raises `x_req` and waits for the destination's `x_ack`, which it synchronizes internally, before releasing. It pairs with the destination-side data synchronizer, so a `DATA_WIDTH` bus crosses domains safely without per-bit synchronization.

---
 rtl/cdc_hs_sender.sv | 116 +++++++++++
 tb/tb_cdc_hs_sender.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_hs_sender.sv
// Source half of a 4-phase req/ack CDC handshake: holds a captured word on x_data while x_req/x_ack cycle.
// Optional handshake timeout with sticky error flag is enabled by defining CDC_HS_TIMEOUT_EN.
module cdc_hs_sender #(
  parameter int DATA_WIDTH     = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  x_req,
  output logic [DATA_WIDTH-1:0] x_data,
  input  logic                  x_ack,
  output logic                  busy,
  output logic                  timeout_err
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("cdc_hs_sender: SYNC_STAGES must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cdc_hs_sender: TIMEOUT_CYCLES must be at least 2");
  end

`ifdef CDC_HS_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, REQ, REL, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
`endif

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic                   accept;
  logic                   to_last;

  // ack synchronizer: the only consumer of the asynchronous x_ack
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_sync <= '0;
    else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], x_ack};
  end
  assign ack_s = ack_sync[SYNC_STAGES-1];

  // A stale ack seen in IDLE blocks new words until the destination lets go
  assign s_ready = (state == IDLE) && !ack_s;
  assign busy    = (state != IDLE);
  assign accept  = s_valid && s_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = REQ;
      REQ: begin
        if (ack_s)        state_nxt = REL;
`ifdef CDC_HS_TIMEOUT_EN
        else if (to_last) state_nxt = DRAIN;
`endif
      end
      REL:  if (!ack_s) state_nxt = IDLE;
`ifdef CDC_HS_TIMEOUT_EN
      DRAIN: if (!ack_s) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // output stage: x_req follows the registered state, x_data loads only on accept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_req  <= 1'b0;
      x_data <= '0;
    end else begin
      x_req <= (state_nxt == REQ);
      if (accept) x_data <= s_data;
    end
  end

`ifdef CDC_HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] to_cnt;
  logic             to_err;
  logic             in_hs;
  logic             hs_entry;

  assign in_hs    = (state == REQ) || (state == REL);
  assign hs_entry = (state_nxt != state) && ((state_nxt == REQ) || (state_nxt == REL));
  assign to_last  = in_hs && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // counter saturates at its last value so a stuck REL keeps flagging without wrap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
      to_err <= 1'b0;
    end else begin
      if (hs_entry)                 to_cnt <= '0;
      else if (in_hs && !to_last)   to_cnt <= to_cnt + 1'b1;
      if ((state == REQ && state_nxt == DRAIN) ||
          (state == REL && state_nxt == REL && to_last))
        to_err <= 1'b1;
    end
  end
  assign timeout_err = to_err;
`else
  assign to_last     = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hs_sender.sv
// Directed bench for cdc_hs_sender with a 2-flop destination model on its own clock (0.73x period).
// Timeout checks are compiled in when CDC_HS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_cdc_hs_sender;
  localparam int DW = 32;
  localparam int SS = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          dclk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          x_req;
  logic [DW-1:0] x_data;
  logic          x_ack;
  logic          busy;
  logic          timeout_err;

  logic          force_ack = 1'b0;
  logic          kill_ack = 1'b0;
  logic          rq1, rq2, dst_ack;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] words[10];

  int n_vec = 0;
  int n_err = 0;
  int hold_viol = 0;
  logic          hold_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;
  realtime t_ack_rise, t_ack_fall, t_req_fall, t_rdy_rise;

  cdc_hs_sender #(.DATA_WIDTH(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .x_req(x_req), .x_data(x_data), .x_ack(x_ack), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  initial begin
    #1.001;
    forever #3.65 dclk = ~dclk;
  end

  // destination: synchronize x_req, echo it as ack, take the word on the request edge
  assign x_ack = force_ack | (dst_ack & ~kill_ack);
  always_ff @(posedge dclk or negedge rst) begin
    if (!rst) begin
      rq1 <= 1'b0; rq2 <= 1'b0; dst_ack <= 1'b0;
    end else begin
      rq1 <= x_req; rq2 <= rq1; dst_ack <= rq2;
    end
  end
  always @(posedge dclk) if (rst && rq2 && !dst_ack) rx_q.push_back(x_data);

  always @(negedge clk) begin
    if (rst && hold_prev && (x_data !== data_prev)) hold_viol <= hold_viol + 1;
    hold_prev <= rst && (x_req | x_ack);
    data_prev <= x_data;
  end

  always @(posedge x_ack)   t_ack_rise <= $realtime;
  always @(negedge x_ack)   t_ack_fall <= $realtime;
  always @(negedge x_req)   t_req_fall <= $realtime;
  always @(posedge s_ready) t_rdy_rise <= $realtime;

  function automatic int edge_idx(input realtime t);
    return int'($floor((t - 5.0) / 10.0));
  endfunction

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int maxc);
    for (int j = 0; j < maxc && !s_ready; j++) @(negedge clk);
  endtask

  task automatic do_xfer(input logic [DW-1:0] w, input string tag);
    wait_ready(60);
    s_data = w; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    wait_ready(80);
    check_val({tag, "_done"}, {31'd0, s_ready}, 32'd1);
    check_val(tag, rx_q.size() > 0 ? rx_q[$] : 32'hxxxxxxxx, w);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_val("rst_in_req", {31'd0, x_req}, 32'd0);
    check_val("rst_in_data", x_data, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_ready", {31'd0, s_ready}, 32'd1);
    check_val("rst_req", {31'd0, x_req}, 32'd0);
    check_val("rst_data", x_data, 32'd0);
    check_val("rst_busy", {31'd0, busy}, 32'd0);
    check_val("rst_terr", {31'd0, timeout_err}, 32'd0);

    // single transfer with latency measurement
    s_data = 32'hDEADBEEF; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check_val("single_req", {31'd0, x_req}, 32'd1);
    check_val("single_data", x_data, 32'hDEADBEEF);
    check_val("single_busy", {31'd0, busy}, 32'd1);
    check_val("single_noready", {31'd0, s_ready}, 32'd0);
    wait_ready(80);
    check_val("single_done", {31'd0, s_ready}, 32'd1);
    check_val("req_fall_lat", 32'(edge_idx(t_req_fall) - edge_idx(t_ack_rise)), 32'(SS + 1));
    check_val("ready_lat", 32'(edge_idx(t_rdy_rise) - edge_idx(t_ack_fall)), 32'(SS + 1));
    check_val("single_rx_cnt", 32'(rx_q.size()), 32'd1);
    check_val("single_rx", rx_q.size() > 0 ? rx_q[0] : 32'hxxxxxxxx, 32'hDEADBEEF);

    // stream with s_valid held high
    rx_q.delete();
    for (int i = 0; i < 10; i++) words[i] = $random;
    s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = words[i];
      wait_ready(80);
      @(negedge clk);
    end
    s_valid = 1'b0;
    for (int j = 0; j < 100 && !(s_ready && rx_q.size() >= 10); j++) @(negedge clk);
    check_val("stream_cnt", 32'(rx_q.size()), 32'd10);
    for (int i = 0; i < 10; i++)
      check_val($sformatf("stream_w%0d", i), i < rx_q.size() ? rx_q[i] : 32'hxxxxxxxx, words[i]);
    check_val("stream_hold", 32'(hold_viol), 32'd0);

    // stale ack in IDLE blocks acceptance
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    s_data = 32'h12345678; s_valid = 1'b1;
    repeat (4) @(negedge clk);
    check_val("fack_ready", {31'd0, s_ready}, 32'd0);
    check_val("fack_nocap", x_data, words[9]);
    check_val("fack_noreq", {31'd0, x_req}, 32'd0);
    force_ack = 1'b0;
    @(negedge clk);
    check_val("frel_c1", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    check_val("frel_c2", {31'd0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0;
    check_val("frel_req", {31'd0, x_req}, 32'd1);
    check_val("frel_data", x_data, 32'h12345678);
    wait_ready(80);
    check_val("frel_rx", rx_q.size() > 0 ? rx_q[$] : 32'hxxxxxxxx, 32'h12345678);

    // reset in the middle of REQ
    s_data = 32'hCAFEF00D; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    check_val("mid_req", {31'd0, x_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check_val("mid_rst_req", {31'd0, x_req}, 32'd0);
    check_val("mid_rst_data", x_data, 32'd0);
    check_val("mid_rst_ready", {31'd0, s_ready}, 32'd1);
    check_val("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("post_rst_ready", {31'd0, s_ready}, 32'd1);
    check_val("post_rst_req", {31'd0, x_req}, 32'd0);
    do_xfer(32'h0BADF00D, "post_rst_xfer");

`ifdef CDC_HS_TIMEOUT_EN
    // ack stuck low: timeout after TO cycles in REQ, then drain to IDLE
    kill_ack = 1'b1;
    s_data = 32'hA5A5A5A5; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (TO - 1) @(negedge clk);
    check_val("to_pre_err", {31'd0, timeout_err}, 32'd0);
    check_val("to_pre_req", {31'd0, x_req}, 32'd1);
    @(negedge clk);
    check_val("to_err", {31'd0, timeout_err}, 32'd1);
    check_val("to_req_drop", {31'd0, x_req}, 32'd0);
    check_val("to_drain", {31'd0, s_ready}, 32'd0);
    @(negedge clk);
    check_val("to_idle", {31'd0, s_ready}, 32'd1);
    repeat (10) @(negedge clk);
    kill_ack = 1'b0;
    repeat (4) @(negedge clk);
    do_xfer(32'h5A5A0001, "to_after_xfer");
    check_val("to_sticky", {31'd0, timeout_err}, 32'd1);
    rst = 1'b0;
    #1;
    check_val("to_rst_clear", {31'd0, timeout_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
`endif

    check_val("final_terr", {31'd0, timeout_err}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
